hazard_fwd_ctrl: RTL and testbench
==================================

Name: hazard_fwd_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core.
- Drives the 2-bit select of both EX-stage operand forwarding 3:1 muxes:
  - 00 = register file
  - 01 = WB result
  - 10 = MEM ALU result
  - 11 = never driven
- Generates stall and flush controls for F/D/E/M for load-use hazards, taken branches and a fixed-latency multi-cycle unit (MDU).
- Sits beside the datapath; it is purely a control block and passes no data.

Parameters:
- REG_ADDR_W, 5, register index width.
- MDU_LATENCY, 4, total EX-stage cycles an MDU op occupies (legal range 2..16).
- PERF_CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- rs1_d, rs2_d  in  REG_ADDR_W  source registers of the instruction in D
- rs1_e, rs2_e  in  REG_ADDR_W  source registers of the instruction in E
- rd_e  in  REG_ADDR_W  destination register of the instruction in E
- load_e  in  1  instruction in E is a load
- pcsrc_e  in  1  taken branch or jump resolved in E
- mdu_start_e  in  1  instruction in E is an MDU op (first EX cycle)
- rd_m, regwrite_m  in  REG_ADDR_W, 1  MEM-stage write-back info
- rd_w, regwrite_w  in  REG_ADDR_W, 1  WB-stage write-back info
- fwd_a_e, fwd_b_e  out  2  operand A/B forwarding mux selects
- stall_f, stall_d, stall_e  out  1  hold pipeline registers
- flush_d, flush_e, flush_m  out  1  insert a bubble into the D/E/M register
- mdu_busy  out  1  MDU multi-cycle sequence in progress

Behaviour:
- Reset:
  - State RUN, counter 0.
  - All stall/flush outputs and mdu_busy = 0.
  - fwd_a_e/fwd_b_e forced to 00 while rst = 1.
- Forwarding (combinational, every cycle, any state). For operand X in {rs1_e, rs2_e}:
  - Select 10 if regwrite_m and rd_m != 0 and rd_m == X.
  - Else select 01 if regwrite_w and rd_w != 0 and rd_w == X.
  - Else select 00.
  - MEM has priority over WB.
  - x0 is never forwarded.
- Load-use detect (lwstall): load_e and rd_e != 0 and (rd_e == rs1_d or rd_e == rs2_d). Evaluated only in RUN.
- FSM states: RUN, MDU_BUSY.
- RUN outputs:
  - stall_f = stall_d = lwstall.
  - flush_d = pcsrc_e.
  - flush_e = lwstall | pcsrc_e.
  - stall_e = flush_m = mdu_busy = 0.
- Simultaneous lwstall and pcsrc_e: both apply. flush_d = 1, flush_e = 1 and stall_f/stall_d = 1; the branch redirect overrides the PC through pcsrc_e.
- RUN -> MDU_BUSY: on mdu_start_e. The counter loads MDU_LATENCY-2 on that edge.
- mdu_start_e cycle in RUN: stall_f = stall_d = stall_e = flush_m = 1. The mdu_start_e-caused stall takes precedence over lwstall.
- MDU_BUSY outputs:
  - mdu_busy = 1.
  - stall_f = stall_d = stall_e = 1.
  - flush_m = 1 while counter != 0.
  - flush_d = flush_e = 0.
  - pcsrc_e, lwstall and mdu_start_e are ignored.
- MDU_BUSY counting: the counter decrements each cycle. In the cycle where counter == 0, all stalls and flush_m deassert, the op advances to M, and the next state is RUN.
- Cycle totals: E is occupied for exactly MDU_LATENCY cycles, with MDU_LATENCY-1 bubbles entering M.
- Reset mid-sequence: returns immediately to RUN with all controls low.
- Counter width: clog2(MDU_LATENCY). No wrap is possible.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds three outputs of PERF_CNT_W bits each:
  - lw_stall_cnt: increments on each cycle with lwstall = 1 in RUN.
  - flush_cnt: increments on each cycle with pcsrc_e = 1 in RUN.
  - mdu_stall_cnt: increments on each cycle with stall_e = 1.
- Counters saturate at all-ones and clear on rst.
- When undefined, these ports and registers do not exist and the behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_t enum: FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - hz_state_t enum: RUN, MDU_BUSY.
  - Default REG_ADDR_W constant.
- Sub-module fwd_sel_unit: one source index plus the M/W write-back info in, fwd_sel_t out. Instantiated twice, for A and B.

Test Plan:
- Forwarding:
  - rs1_e = 5, rd_m = 5, regwrite_m = 1, rd_w = 5, regwrite_w = 1 -> fwd_a_e = 10.
  - Drop regwrite_m -> fwd_a_e = 01.
  - rs1_e = 0 with rd_m = 0 -> fwd_a_e = 00.
- Load-use: load_e = 1, rd_e = 7, rs2_d = 7 -> exactly one cycle of stall_f = stall_d = flush_e = 1, with flush_d = 0.
- Branch: pcsrc_e = 1 -> flush_d = flush_e = 1 for one cycle with no stalls. When pcsrc_e and lwstall are simultaneous -> flush_d = flush_e = stall_f = stall_d = 1.
- MDU with MDU_LATENCY = 4, mdu_start_e pulse:
  - stall_e high for 3 cycles, flush_m high for 3 cycles.
  - mdu_busy high for 2 cycles.
  - Then RUN; pcsrc_e = 1 during busy produces no flush.
- Reset asserted asynchronously in the second MDU_BUSY cycle -> all controls 0 immediately; after release, state is RUN.
- HAZARD_PERF_CNT_EN: after 3 load-use events, 2 branches and 1 MDU op (latency 4) -> lw_stall_cnt = 3, flush_cnt = 2, mdu_stall_cnt = 3.

Source files
------------

// File: rtl/hazard_fwd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the 5-stage core hazard/forwarding controller.
//   fwd_sel_t  : EX operand forwarding mux select (3:1 mux, 2'b11 never used)
//   hz_state_t : hazard controller FSM state
//   HZ_REG_ADDR_W : default register index width
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam int HZ_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,  // operand from register file
    FWD_WB  = 2'b01,  // operand from WB-stage result
    FWD_MEM = 2'b10   // operand from MEM-stage ALU result
  } fwd_sel_t;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel.sv
// -----------------------------------------------------------------------------
// fwd_sel_unit
// Forwarding select for one EX-stage source operand. MEM beats WB, and
// register x0 is never forwarded.
// Ports:
//   src              in   source register index of the operand in E
//   rd_m, regwrite_m in   MEM-stage destination / write enable
//   rd_w, regwrite_w in   WB-stage destination / write enable
//   sel              out  forwarding mux select (fwd_sel_t)
// -----------------------------------------------------------------------------
module fwd_sel_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = HZ_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic                  regwrite_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  regwrite_w,
  output fwd_sel_t              sel
);

  logic hit_m;
  logic hit_w;

  assign hit_m = regwrite_m && (rd_m != '0) && (rd_m == src);
  assign hit_w = regwrite_w && (rd_w != '0) && (rd_w == src);

  // MEM holds the younger result, so it wins when both stages match.
  always_comb begin
    if (hit_m)      sel = FWD_MEM;
    else if (hit_w) sel = FWD_WB;
    else            sel = FWD_RF;
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl
// Hazard controller for the 5-stage core: EX operand forwarding selects plus
// stall/flush controls for load-use hazards, taken branches and the
// fixed-latency multi-cycle unit (MDU). Control only; no data passes through.
//
// Optional feature (macro HAZARD_PERF_CNT_EN): adds saturating performance
// counters lw_stall_cnt, flush_cnt and mdu_stall_cnt (PERF_CNT_W bits each).
//
// Ports:
//   clk, rst                 core clock, asynchronous active-high reset
//   rs1_d, rs2_d             sources of the instruction in D
//   rs1_e, rs2_e, rd_e       sources / destination of the instruction in E
//   load_e, pcsrc_e          E is a load / taken branch or jump resolved in E
//   mdu_start_e              E holds an MDU op in its first EX cycle
//   rd_m, regwrite_m         MEM-stage write-back info
//   rd_w, regwrite_w         WB-stage write-back info
//   fwd_a_e, fwd_b_e         operand A/B forwarding selects
//   stall_f/d/e              hold the F/D/E pipeline registers
//   flush_d/e/m              bubble into the D/E/M pipeline registers
//   mdu_busy                 MDU multi-cycle sequence in progress
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = HZ_REG_ADDR_W,
  parameter int MDU_LATENCY = 4,
  parameter int PERF_CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rs1_e,
  input  logic [REG_ADDR_W-1:0] rs2_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic                  load_e,
  input  logic                  pcsrc_e,
  input  logic                  mdu_start_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic                  regwrite_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  regwrite_w,
  output logic [1:0]            fwd_a_e,
  output logic [1:0]            fwd_b_e,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  flush_m,
`ifdef HAZARD_PERF_CNT_EN
  output logic [PERF_CNT_W-1:0] lw_stall_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt,
  output logic [PERF_CNT_W-1:0] mdu_stall_cnt,
`endif
  output logic                  mdu_busy
);

  // Counter holds the remaining stall cycles after the start cycle; its
  // largest value is MDU_LATENCY-2, which always fits in clog2(MDU_LATENCY).
  localparam int CNT_W = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LATENCY - 2);

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
  fwd_sel_t sel_a;
  fwd_sel_t sel_b;

  fwd_sel_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .src        (rs1_e),
    .rd_m       (rd_m),
    .regwrite_m (regwrite_m),
    .rd_w       (rd_w),
    .regwrite_w (regwrite_w),
    .sel        (sel_a)
  );

  fwd_sel_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .src        (rs2_e),
    .rd_m       (rd_m),
    .regwrite_m (regwrite_m),
    .rd_w       (rd_w),
    .regwrite_w (regwrite_w),
    .sel        (sel_b)
  );

  assign fwd_a_e = rst ? FWD_RF : sel_a;
  assign fwd_b_e = rst ? FWD_RF : sel_b;

  // ---------------------------------------------------------------------------
  // Hazard FSM
  // ---------------------------------------------------------------------------
  hz_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lwstall;

  assign lwstall = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

  // NOTE: every output and next-state value gets a default before the case so
  // no path leaves a variable unassigned; that is what keeps this latch-free.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_m   = 1'b0;
    mdu_busy  = 1'b0;

    // Controls are held low for the whole time reset is asserted, not only
    // after the next edge, so a mid-cycle reset silences them at once.
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (mdu_start_e) begin
            // MDU stall dominates; a load-use or redirect cannot coexist
            // with an MDU op occupying E.
            stall_f   = 1'b1;
            stall_d   = 1'b1;
            stall_e   = 1'b1;
            flush_m   = 1'b1;
            state_nxt = MDU_BUSY;
            cnt_nxt   = CNT_LOAD;
          end else begin
            // Load-use and branch redirect both apply when simultaneous; the
            // PC redirect itself comes from pcsrc_e.
            stall_f = lwstall;
            stall_d = lwstall;
            flush_d = pcsrc_e;
            flush_e = lwstall | pcsrc_e;
          end
        end
        MDU_BUSY: begin
          if (cnt != '0) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_e  = 1'b1;
            flush_m  = 1'b1;
            mdu_busy = 1'b1;
            cnt_nxt  = cnt - 1'b1;
          end else begin
            // Final EX cycle: release everything so the op advances to M.
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic lw_inc, fl_inc;

  assign lw_inc = (state == RUN) && !mdu_start_e && lwstall;
  assign fl_inc = (state == RUN) && !mdu_start_e && pcsrc_e;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lw_stall_cnt  <= '0;
      flush_cnt     <= '0;
      mdu_stall_cnt <= '0;
    end else begin
      if (lw_inc  && (lw_stall_cnt  != '1)) lw_stall_cnt  <= lw_stall_cnt  + 1'b1;
      if (fl_inc  && (flush_cnt     != '1)) flush_cnt     <= flush_cnt     + 1'b1;
      if (stall_e && (mdu_stall_cnt != '1)) mdu_stall_cnt <= mdu_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
// Self-checking bench for hazard_fwd_ctrl: directed scenarios followed by
// random stimulus, all compared against a cycle-level reference model that
// tracks how many EX cycles the current MDU op still occupies.
// -----------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;

  localparam int AW  = 5;
  localparam int LAT = 4;
  localparam int PW  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic          load_e, pcsrc_e, mdu_start_e, regwrite_m, regwrite_w;
  logic [1:0]    fwd_a_e, fwd_b_e;
  logic          stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [PW-1:0] lw_stall_cnt, flush_cnt, mdu_stall_cnt;
`endif

  hazard_fwd_ctrl #(.REG_ADDR_W(AW), .MDU_LATENCY(LAT), .PERF_CNT_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .rs1_e       (rs1_e),
    .rs2_e       (rs2_e),
    .rd_e        (rd_e),
    .load_e      (load_e),
    .pcsrc_e     (pcsrc_e),
    .mdu_start_e (mdu_start_e),
    .rd_m        (rd_m),
    .regwrite_m  (regwrite_m),
    .rd_w        (rd_w),
    .regwrite_w  (regwrite_w),
    .fwd_a_e     (fwd_a_e),
    .fwd_b_e     (fwd_b_e),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .stall_e     (stall_e),
    .flush_d     (flush_d),
    .flush_e     (flush_e),
    .flush_m     (flush_m),
`ifdef HAZARD_PERF_CNT_EN
    .lw_stall_cnt  (lw_stall_cnt),
    .flush_cnt     (flush_cnt),
    .mdu_stall_cnt (mdu_stall_cnt),
`endif
    .mdu_busy    (mdu_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int mdu_left = 0;          // EX cycles the MDU op still occupies after this one
  int n_se, n_fm, n_busy;    // per-sequence counts of observed outputs

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [AW-1:0] x);
    if (regwrite_m && rd_m != 0 && rd_m == x) return 2'b10;
    if (regwrite_w && rd_w != 0 && rd_w == x) return 2'b01;
    return 2'b00;
  endfunction

  // Expected {fwd_a, fwd_b, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_busy}
  function automatic logic [10:0] ref_out();
    logic sf, sd, se, fd, fe, fm, bz, lw;
    sf = 0; sd = 0; se = 0; fd = 0; fe = 0; fm = 0; bz = 0;
    if (rst) return 11'd0;
    if (mdu_left == 0) begin
      if (mdu_start_e) begin
        sf = 1; sd = 1; se = 1; fm = 1;
      end else begin
        lw = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
        sf = lw; sd = lw; fd = pcsrc_e; fe = lw || pcsrc_e;
      end
    end else if (mdu_left > 1) begin
      sf = 1; sd = 1; se = 1; fm = 1; bz = 1;
    end
    return {ref_fwd(rs1_e), ref_fwd(rs2_e), sf, sd, se, fd, fe, fm, bz};
  endfunction

  task automatic ref_advance();
    if (rst) mdu_left = 0;
    else if (mdu_left == 0 && mdu_start_e) mdu_left = LAT - 1;
    else if (mdu_left > 0) mdu_left--;
  endtask

  task automatic idle();
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {load_e, pcsrc_e, mdu_start_e, regwrite_m, regwrite_w} = '0;
  endtask

  // Called 1 time unit after a rising edge with inputs already driven:
  // compares mid-cycle, advances the model, and returns 1 unit after next edge.
  task automatic cycle(input string tag);
    #4;
    check(tag, {fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_busy},
          ref_out());
    n_se   += int'(stall_e);
    n_fm   += int'(flush_m);
    n_busy += int'(mdu_busy);
    ref_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    mdu_left = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #3;
    // Reset state: forwarding forced to RF even with a matching MEM write.
    rs1_e = 5; rd_m = 5; regwrite_m = 1;
    #1;
    check("reset_fwd_a", fwd_a_e, 2'b00);
    check("reset_ctrl", {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_busy}, 7'd0);
    do_reset();

    // Forwarding priority and x0.
    rs1_e = 5; rd_m = 5; regwrite_m = 1; rd_w = 5; regwrite_w = 1;
    #1; check("fwd_mem_prio", fwd_a_e, 2'b10); #(-0);
    cycle("fwd_mem_vec");
    regwrite_m = 0;
    #1; check("fwd_wb", fwd_a_e, 2'b01);
    cycle("fwd_wb_vec");
    rs1_e = 0; rd_m = 0; regwrite_m = 1; rd_w = 0;
    #1; check("fwd_x0", fwd_a_e, 2'b00);
    rs2_e = 9; rd_w = 9; regwrite_w = 1;
    cycle("fwd_b_wb_vec");
    idle();

    // Load-use: one cycle of stall_f/stall_d/flush_e, no flush_d.
    load_e = 1; rd_e = 7; rs2_d = 7;
    #1; check("lw_ctrl", {stall_f, stall_d, flush_d, flush_e}, 4'b1101);
    cycle("lw_vec");
    idle();
    cycle("lw_after");

    // Branch alone, then branch with simultaneous load-use.
    pcsrc_e = 1;
    #1; check("br_ctrl", {stall_f, stall_d, flush_d, flush_e}, 4'b0011);
    cycle("br_vec");
    load_e = 1; rd_e = 3; rs1_d = 3;
    #1; check("br_lw_ctrl", {stall_f, stall_d, flush_d, flush_e}, 4'b1111);
    cycle("br_lw_vec");
    idle();

    // MDU sequence; pcsrc_e during busy must not flush.
    n_se = 0; n_fm = 0; n_busy = 0;
    mdu_start_e = 1;
    cycle("mdu_start");
    mdu_start_e = 0; pcsrc_e = 1;
    for (int i = 0; i < 6; i++) cycle("mdu_seq");
    check("mdu_stall_e_cycles", n_se, 3);
    check("mdu_flush_m_cycles", n_fm, 3);
    check("mdu_busy_cycles", n_busy, 2);
    idle();

    // Async reset in the second MDU_BUSY cycle.
    mdu_start_e = 1;
    cycle("mdu_start2");
    mdu_start_e = 0;
    cycle("mdu_busy1");
    #2;
    rs1_e = 4; rd_m = 4; regwrite_m = 1;
    rst = 1'b1;
    #1;
    check("rst_mid_ctrl", {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_busy}, 7'd0);
    check("rst_mid_fwd", fwd_a_e, 2'b00);
    mdu_left = 0;
    @(negedge clk);
    rst = 1'b0;
    idle();
    @(posedge clk);
    #1;
    check("rst_run_busy", mdu_busy, 1'b0);
    load_e = 1; rd_e = 2; rs1_d = 2;
    cycle("rst_run_lw");
    idle();

`ifdef HAZARD_PERF_CNT_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      load_e = 1; rd_e = 6; rs1_d = 6;
      cycle("perf_lw");
      idle();
      cycle("perf_gap");
    end
    for (int i = 0; i < 2; i++) begin
      pcsrc_e = 1;
      cycle("perf_br");
      idle();
    end
    mdu_start_e = 1;
    cycle("perf_mdu");
    idle();
    for (int i = 0; i < 4; i++) cycle("perf_tail");
    check("perf_lw_cnt", lw_stall_cnt, 3);
    check("perf_flush_cnt", flush_cnt, 2);
    check("perf_mdu_cnt", mdu_stall_cnt, 3);
`endif

    // Random stimulus against the model.
    for (int i = 0; i < 2000; i++) begin
      rs1_d = AW'($urandom_range(0, 7));
      rs2_d = AW'($urandom_range(0, 7));
      rs1_e = AW'($urandom_range(0, 7));
      rs2_e = AW'($urandom_range(0, 7));
      rd_e  = AW'($urandom_range(0, 7));
      rd_m  = AW'($urandom_range(0, 7));
      rd_w  = AW'($urandom_range(0, 7));
      regwrite_m  = $urandom_range(0, 1) == 1;
      regwrite_w  = $urandom_range(0, 1) == 1;
      load_e      = $urandom_range(0, 2) == 0;
      pcsrc_e     = $urandom_range(0, 4) == 0;
      mdu_start_e = $urandom_range(0, 11) == 0;
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
